// File: rtl/imm_extend_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : imm_extend_ctrl                                                   |
// | Brief   : ID-stage immediate decode/extend with a 2-entry skid buffer.      |
// |           Optional perf counters enabled by defining IMM_PERF_EN.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module imm_extend_ctrl #(
  parameter int XLEN        = 32,
  parameter int IMM_W       = 16,
  parameter int ZERO_UNUSED = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_mode,
  output logic            out_imm_used
`ifdef IMM_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [7:0]      perf_flush_cnt
`endif
);

  localparam logic [1:0] c_MODE_SIGN   = 2'b00;
  localparam logic [1:0] c_MODE_ZERO   = 2'b01;
  localparam logic [1:0] c_MODE_UPPER  = 2'b10;
  localparam logic [1:0] c_MODE_BRANCH = 2'b11;

  logic [5:0]       w_opcode;
  logic [IMM_W-1:0] w_imm;
  logic [XLEN-1:0]  w_sext;
  logic [XLEN-1:0]  w_otherImm;
  logic [XLEN-1:0]  w_decImm;
  logic [1:0]       w_decMode;
  logic             w_decUsed;
  logic             w_unusedInstrBits;

  assign w_opcode          = in_instr[31:26];
  assign w_imm             = in_instr[IMM_W-1:0];
  assign w_sext            = {{(XLEN-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_unusedInstrBits = ^in_instr[25:IMM_W];

  generate
    if (ZERO_UNUSED != 0) begin : g_zeroUnused
      assign w_otherImm = '0;
    end else begin : g_signUnused
      assign w_otherImm = w_sext;
    end
  endgenerate

  always_comb begin
    w_decImm  = w_otherImm;
    w_decMode = c_MODE_SIGN;
    w_decUsed = 1'b0;
    case (w_opcode)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        w_decImm  = w_sext;
        w_decMode = c_MODE_SIGN;
        w_decUsed = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_decImm  = {{(XLEN-IMM_W){1'b0}}, w_imm};
        w_decMode = c_MODE_ZERO;
        w_decUsed = 1'b1;
      end
      6'h0F: begin
        w_decImm  = {w_imm, {(XLEN-IMM_W){1'b0}}};
        w_decMode = c_MODE_UPPER;
        w_decUsed = 1'b1;
      end
      6'h04, 6'h05: begin
        w_decImm  = {w_sext[XLEN-3:0], 2'b00};
        w_decMode = c_MODE_BRANCH;
        w_decUsed = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Head entry drives the outputs directly; skid holds the one entry behind it.
  logic            r_headValid, r_skidValid, r_inReady;
  logic [XLEN-1:0] r_headImm, r_skidImm;
  logic [1:0]      r_headMode, r_skidMode;
  logic            r_headUsed, r_skidUsed;
  logic            w_push, w_pop;
  logic            w_headValidNxt, w_skidValidNxt;
  logic            w_headFromSkid, w_headFromIn, w_skidFromIn;

  assign w_push = in_valid && r_inReady && !flush;
  assign w_pop  = r_headValid && out_ready;

  always_comb begin
    w_headValidNxt = r_headValid;
    w_skidValidNxt = r_skidValid;
    if (flush) begin
      w_headValidNxt = 1'b0;
      w_skidValidNxt = 1'b0;
    end else if (w_pop) begin
      if (r_skidValid) begin
        w_headValidNxt = 1'b1;
        w_skidValidNxt = w_push;
      end else begin
        w_headValidNxt = w_push;
      end
    end else if (w_push) begin
      if (!r_headValid) w_headValidNxt = 1'b1;
      else              w_skidValidNxt = 1'b1;
    end
  end

  assign w_headFromSkid = !flush && w_pop && r_skidValid;
  assign w_headFromIn   = w_push && (!r_headValid || (w_pop && !r_skidValid));
  assign w_skidFromIn   = w_push && r_headValid && (!w_pop || r_skidValid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_headValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
      r_headImm   <= '0;
      r_headMode  <= c_MODE_SIGN;
      r_headUsed  <= 1'b0;
      r_skidImm   <= '0;
      r_skidMode  <= c_MODE_SIGN;
      r_skidUsed  <= 1'b0;
    end else begin
      r_headValid <= w_headValidNxt;
      r_skidValid <= w_skidValidNxt;
      r_inReady   <= !(w_headValidNxt && w_skidValidNxt);
      if (w_headFromSkid) begin
        r_headImm  <= r_skidImm;
        r_headMode <= r_skidMode;
        r_headUsed <= r_skidUsed;
      end else if (w_headFromIn) begin
        r_headImm  <= w_decImm;
        r_headMode <= w_decMode;
        r_headUsed <= w_decUsed;
      end
      if (w_skidFromIn) begin
        r_skidImm  <= w_decImm;
        r_skidMode <= w_decMode;
        r_skidUsed <= w_decUsed;
      end
    end
  end

  assign in_ready     = r_inReady;
  assign out_valid    = r_headValid;
  assign out_imm      = r_headImm;
  assign out_mode     = r_headMode;
  assign out_imm_used = r_headUsed;

`ifdef IMM_PERF_EN
  logic [15:0] r_stallCnt;
  logic [7:0]  r_flushCnt;

  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (r_headValid && !out_ready && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (flush && (r_headValid || r_skidValid) && (r_flushCnt != 8'hFF))
        r_flushCnt <= r_flushCnt + 8'd1;
    end
  end

  assign perf_stall_cnt = r_stallCnt;
  assign perf_flush_cnt = r_flushCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_imm_extend_ctrl                                                |
// | Brief   : Directed self-checking bench for imm_extend_ctrl.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_imm_extend_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_mode;
  logic        out_imm_used;
`ifdef IMM_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [7:0]  perf_flush_cnt;
`endif

  int checks;
  int failures;

  imm_extend_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_imm      (out_imm),
    .out_mode     (out_mode),
    .out_imm_used (out_imm_used)
`ifdef IMM_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_mode !== 2'b00 || out_imm_used !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b imm=%h mode=%b used=%b want v=0 imm=0 mode=00 used=0",
               out_valid, out_imm, out_mode, out_imm_used);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
`ifdef IMM_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_perf: got stall=%0d flush=%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_decode();
    logic [31:0] vInstr [9];
    logic [31:0] vImm   [9];
    logic [1:0]  vMode  [9];
    logic        vUsed  [9];
    vInstr[0] = 32'h2001FFFC; vImm[0] = 32'hFFFFFFFC; vMode[0] = 2'b00; vUsed[0] = 1'b1;
    vInstr[1] = 32'h34018000; vImm[1] = 32'h00008000; vMode[1] = 2'b01; vUsed[1] = 1'b1;
    vInstr[2] = 32'h3C011234; vImm[2] = 32'h12340000; vMode[2] = 2'b10; vUsed[2] = 1'b1;
    vInstr[3] = 32'h1000FFFF; vImm[3] = 32'hFFFFFFFC; vMode[3] = 2'b11; vUsed[3] = 1'b1;
    vInstr[4] = 32'h00221820; vImm[4] = 32'h00000000; vMode[4] = 2'b00; vUsed[4] = 1'b0;
    vInstr[5] = 32'h8C220010; vImm[5] = 32'h00000010; vMode[5] = 2'b00; vUsed[5] = 1'b1;
    vInstr[6] = 32'h30018001; vImm[6] = 32'h00008001; vMode[6] = 2'b01; vUsed[6] = 1'b1;
    vInstr[7] = 32'h14000003; vImm[7] = 32'h0000000C; vMode[7] = 2'b11; vUsed[7] = 1'b1;
    vInstr[8] = 32'h08008000; vImm[8] = 32'h00000000; vMode[8] = 2'b00; vUsed[8] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = vInstr[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== vImm[i] || out_mode !== vMode[i] || out_imm_used !== vUsed[i]) begin
        failures++;
        $display("FAIL decode_%0d instr=%h: got v=%b imm=%h mode=%b used=%b want v=1 imm=%h mode=%b used=%b",
                 i, vInstr[i], out_valid, out_imm, out_mode, out_imm_used, vImm[i], vMode[i], vUsed[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL decode_drain_%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h20010001;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 32'h1) begin
      failures++;
      $display("FAIL bp_first: got rdy=%b v=%b imm=%h want 1/1/00000001", in_ready, out_valid, out_imm);
    end
    in_instr = 32'h20010002;
    @(negedge clk);
    in_instr = 32'h20010003;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h1 || out_mode !== 2'b00 || out_imm_used !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall_%0d: got rdy=%b v=%b imm=%h mode=%b used=%b want 0/1/00000001/00/1",
                 i, in_ready, out_valid, out_imm, out_mode, out_imm_used);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h2 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: got v=%b imm=%h rdy=%b want 1/00000002/1", out_valid, out_imm, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h3) begin
      failures++;
      $display("FAIL bp_third: got v=%b imm=%h want 1/00000003", out_valid, out_imm);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
    end
`ifdef IMM_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd4) begin
      failures++;
      $display("FAIL bp_perf_stall: got %0d want 4", perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'(i)) begin
          failures++;
          $display("FAIL stream_out_%0d: got v=%b imm=%h want 1/%h", i, out_valid, out_imm, 32'(i));
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready_%0d: got in_ready=%b want 1", i, in_ready);
      end
      if (i < 10) begin
        in_valid = 1'b1;
        in_instr = 32'h20010000 | 32'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h20010011;
    @(negedge clk);
    in_instr  = 32'h20010022;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_imm !== 32'h11) begin
      failures++;
      $display("FAIL flush_full: got rdy=%b imm=%h want 0/00000011", in_ready, out_imm);
    end
    flush    = 1'b1;
    in_instr = 32'h20010033;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full_after: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    flush    = 1'b0;
    in_instr = 32'h20010044;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h44) begin
      failures++;
      $display("FAIL flush_refill: got v=%b imm=%h want 1/00000044", out_valid, out_imm);
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h20010055;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_drop: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_ghost: got out_valid=%b imm=%h want 0", out_valid, out_imm);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef IMM_PERF_EN
    checks++;
    if (perf_flush_cnt !== 8'd2) begin
      failures++;
      $display("FAIL flush_perf: got %0d want 2", perf_flush_cnt);
    end
`endif
    in_valid = 1'b1;
    in_instr = 32'h20010066;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h66) begin
      failures++;
      $display("FAIL flush_resume: got v=%b imm=%h want 1/00000066", out_valid, out_imm);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h20010077;
    @(negedge clk);
    in_instr  = 32'h20010088;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_imm_used !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: got v=%b used=%b want 0/0", out_valid, out_imm_used);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
`ifdef IMM_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL areset_perf: got %0d want 0", perf_stall_cnt);
    end
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h3C0100AB;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h00AB0000 || out_mode !== 2'b10 || out_imm_used !== 1'b1) begin
      failures++;
      $display("FAIL areset_first: got v=%b imm=%h mode=%b used=%b want 1/00AB0000/10/1",
               out_valid, out_imm, out_mode, out_imm_used);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
